// File: rtl/svga_pkg.sv
// Shared SVGA text-path definitions: screen coordinate widths, glyph defaults,
// glyph ROM address packing and the per-pixel tap carried alongside the ROM read.
package svga_pkg;

    localparam int COORD_W     = 10;
    localparam int CALC_W      = 12;
    localparam int GLYPH_W_DEF = 16;
    localparam int GLYPH_H_DEF = 16;

    // Pixel attributes that must wait for the glyph ROM byte.
    typedef struct packed {
        logic       in_box;
        logic       blank;
        logic [2:0] bit_idx;
    } tap_t;

    // Glyph ROM address is {code, row, byte}, most significant first.
    function automatic int unsigned rom_pack(int unsigned code, int unsigned row,
                                             int unsigned byte_sel, int row_w, int byte_w);
        return (code << (row_w + byte_w)) | (row << byte_w) | byte_sel;
    endfunction

endpackage

// File: rtl/text_buf.sv
// Character buffer: NCHAR entries of {blink, code}, one write port and one
// combinational read port. Entries reset to identity codes with blink cleared.
module text_buf
    import svga_pkg::*;
#(
    parameter int NCHAR  = 16,
    parameter int CODE_W = 5,
    localparam int IDX_W = $clog2(NCHAR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              wr_blink,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CODE_W-1:0] rd_code,
    output logic              rd_blink
);

    logic [CODE_W:0] ent_d [NCHAR];
    logic [CODE_W:0] ent_q [NCHAR];

    always_comb begin
        for (int i = 0; i < NCHAR; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (wr_en) begin
            ent_d[wr_idx] = {wr_blink, wr_code};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHAR; i++) begin
                ent_q[i] <= {1'b0, CODE_W'(i)};
            end
        end else begin
            for (int i = 0; i < NCHAR; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Reads see the registered contents, so a same-edge write is visible next edge.
    assign rd_code  = ent_q[rd_idx][CODE_W-1:0];
    assign rd_blink = ent_q[rd_idx][CODE_W];

endmodule

// File: rtl/text_overlay.sv
// Scaled, blinking text string renderer: maps scan position to a glyph ROM
// address, then combines the returned byte with delayed attributes into a pixel.
module text_overlay
    import svga_pkg::*;
#(
    parameter int NCHAR      = 16,
    parameter int CODE_W     = 5,
    parameter int GLYPH_W    = GLYPH_W_DEF,
    parameter int GLYPH_H    = GLYPH_H_DEF,
    parameter int SCALE_W    = 2,
    parameter int ROM_LAT    = 1,
    parameter int BLINK_LOG2 = 5,
    localparam int IDX_W  = $clog2(NCHAR),
    localparam int ROW_W  = $clog2(GLYPH_H),
    localparam int BYTE_W = (GLYPH_W == 16) ? 1 : 0,
    localparam int ADDR_W = CODE_W + ROW_W + BYTE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [SCALE_W-1:0] scale,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [CODE_W-1:0]  wr_code,
    input  logic               wr_blink,
    input  logic               frame_tick,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               pixel,
    output logic               in_box
);

    localparam int COL_W = $clog2(GLYPH_W);

    logic [CALC_W-1:0] dx, dy, sx, sy;
    logic [31:0]       box_w, box_h;
    logic              hit;
    logic [IDX_W-1:0]  char_idx;
    logic [CODE_W-1:0] rd_code;
    logic              rd_blink;

    // Compare against 32-bit limits so large scales never alias back into the box.
    always_comb begin
        dx       = CALC_W'(x_pos) - CALC_W'(x0);
        dy       = CALC_W'(y_pos) - CALC_W'(y0);
        box_w    = 32'(NCHAR * GLYPH_W) << scale;
        box_h    = 32'(GLYPH_H) << scale;
        hit      = (x_pos >= x0) && (y_pos >= y0) && (32'(dx) < box_w) && (32'(dy) < box_h);
        sx       = dx >> scale;
        sy       = dy >> scale;
        char_idx = sx[COL_W +: IDX_W];
    end

    logic unused_bits;
    assign unused_bits = ^{sx[CALC_W-1:COL_W+IDX_W], sy[CALC_W-1:ROW_W]};

    text_buf #(
        .NCHAR  (NCHAR),
        .CODE_W (CODE_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_code  (wr_code),
        .wr_blink (wr_blink),
        .rd_idx   (char_idx),
        .rd_code  (rd_code),
        .rd_blink (rd_blink)
    );

    logic [ADDR_W-1:0]     rom_addr_d, rom_addr_q;
    tap_t                  tap_a_d, tap_a_q;
    logic [BLINK_LOG2-1:0] blink_d, blink_q;

    always_comb begin
        rom_addr_d = '0;
        tap_a_d    = '0;
        if (hit) begin
            rom_addr_d = ADDR_W'(rom_pack(32'(rd_code), 32'(sy[ROW_W-1:0]),
                                          (GLYPH_W == 16) ? 32'(sx[3]) : 32'd0,
                                          ROW_W, BYTE_W));
            tap_a_d.in_box  = 1'b1;
            tap_a_d.blank   = rd_blink & blink_q[BLINK_LOG2-1];
            tap_a_d.bit_idx = sx[2:0];
        end
        blink_d = blink_q + BLINK_LOG2'(frame_tick);
    end

    tap_t tap_d [ROM_LAT];
    tap_t tap_q [ROM_LAT];

    always_comb begin
        tap_d[0] = tap_a_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            tap_d[i] = tap_q[i-1];
        end
    end

    tap_t tap_b;
    logic pixel_d, pixel_q, in_box_d, in_box_q;

    // Bit 7 of the ROM byte is the leftmost pixel of its 8-pixel group.
    assign tap_b = tap_q[ROM_LAT-1];
    always_comb begin
        pixel_d  = tap_b.in_box & ~tap_b.blank & rom_data[3'd7 - tap_b.bit_idx];
        in_box_d = tap_b.in_box;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            tap_a_q    <= '0;
            blink_q    <= '0;
            pixel_q    <= 1'b0;
            in_box_q   <= 1'b0;
            for (int i = 0; i < ROM_LAT; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            rom_addr_q <= rom_addr_d;
            tap_a_q    <= tap_a_d;
            blink_q    <= blink_d;
            pixel_q    <= pixel_d;
            in_box_q   <= in_box_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                tap_q[i] <= tap_d[i];
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign pixel    = pixel_q;
    assign in_box   = in_box_q;

endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: directed scenarios plus randomized scan
// traffic, compared every cycle against an arithmetic model of the string box.
module tb_text_overlay;

    localparam int NCHAR      = 16;
    localparam int CODE_W     = 5;
    localparam int GW         = 16;
    localparam int GH         = 16;
    localparam int SCALE_W    = 2;
    localparam int ROM_LAT    = 1;
    localparam int BLINK_LOG2 = 5;
    localparam int ADDR_W     = 10;
    localparam int LAT        = 2 + ROM_LAT;

    logic              clk;
    logic              rst_n;
    logic [9:0]        x_pos, y_pos, x0, y0;
    logic [SCALE_W-1:0] scale;
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [CODE_W-1:0] wr_code;
    logic              wr_blink;
    logic              frame_tick;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              pixel;
    logic              in_box;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    text_overlay #(
        .NCHAR(NCHAR), .CODE_W(CODE_W), .GLYPH_W(GW), .GLYPH_H(GH),
        .SCALE_W(SCALE_W), .ROM_LAT(ROM_LAT), .BLINK_LOG2(BLINK_LOG2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .x0(x0), .y0(y0),
        .scale(scale), .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
        .wr_blink(wr_blink), .frame_tick(frame_tick), .rom_addr(rom_addr),
        .rom_data(rom_data), .pixel(pixel), .in_box(in_box)
    );

    // External synchronous glyph ROM with ROM_LAT cycles of latency.
    logic [7:0] mem [0:1023];
    logic [7:0] rpipe [ROM_LAT];
    always @(posedge clk) begin
        rpipe[0] <= mem[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign rom_data = rpipe[ROM_LAT-1];

    typedef struct {
        int addr;
        bit pix;
        bit box;
    } exp_t;

    int   mcode  [NCHAR];
    bit   mblink [NCHAR];
    int   mcnt;
    exp_t hist   [LAT];

    function automatic exp_t predict();
        exp_t e;
        int x, y, ax, ay, m, sx, ch, col, row;
        bit blank;
        e  = '{default: 0};
        x  = int'(x_pos);
        y  = int'(y_pos);
        ax = int'(x0);
        ay = int'(y0);
        m  = 1 << scale;
        if (x >= ax && y >= ay && (x - ax) < NCHAR * GW * m && (y - ay) < GH * m) begin
            sx     = (x - ax) / m;
            ch     = sx / GW;
            col    = sx % GW;
            row    = (y - ay) / m;
            e.addr = (mcode[ch] * GH + row) * (GW / 8) + col / 8;
            blank  = mblink[ch] && (mcnt >= (1 << (BLINK_LOG2 - 1)));
            e.pix  = !blank && mem[e.addr][7 - col % 8];
            e.box  = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHAR; i++) begin
                mcode[i]  <= i % (1 << CODE_W);
                mblink[i] <= 1'b0;
            end
            mcnt <= 0;
            for (int i = 0; i < LAT; i++) hist[i] <= '{default: 0};
        end else begin
            hist[0] <= predict();
            for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
            if (wr_en) begin
                mcode[wr_idx]  <= int'(wr_code);
                mblink[wr_idx] <= wr_blink;
            end
            if (frame_tick) mcnt <= (mcnt + 1) % (1 << BLINK_LOG2);
        end
    end

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_addr", int'(rom_addr), 0);
            check("rst_pixel", int'(pixel), 0);
            check("rst_in_box", int'(in_box), 0);
        end else begin
            check("model_addr", int'(rom_addr), hist[0].addr);
            check("model_pixel", int'(pixel), int'(hist[LAT-1].pix));
            check("model_in_box", int'(in_box), int'(hist[LAT-1].box));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic at_xy(input int x, input int y);
        x_pos = 10'(x);
        y_pos = 10'(y);
    endtask

    initial begin
        rst_n = 1'b0; x_pos = '0; y_pos = '0; x0 = '0; y0 = '0; scale = '0;
        wr_en = 1'b0; wr_idx = '0; wr_code = '0; wr_blink = 1'b0; frame_tick = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0]   = 8'h80;
        mem[545] = 8'h40;
        mem[288] = 8'hFF;
        step(3);
        check("reset_addr", int'(rom_addr), 0);
        check("reset_pixel", int'(pixel), 0);
        rst_n = 1'b1;
        step(1);

        // Anchor pixel: code 0 row 0 byte 0, leftmost bit of 8'h80.
        x0 = 10'd100; y0 = 10'd50; scale = '0;
        at_xy(100, 50);
        step(1);
        check("t1_addr", int'(rom_addr), 0);
        step(LAT - 1);
        check("t1_pixel", int'(pixel), 1);
        check("t1_in_box", int'(in_box), 1);

        // Box edges.
        at_xy(99, 50);  step(LAT); check("t2_left", int'(in_box), 0); check("t2_left_pix", int'(pixel), 0);
        at_xy(100, 49); step(LAT); check("t2_top", int'(in_box), 0);
        at_xy(355, 50); step(LAT); check("t2_right_in", int'(in_box), 1);
        at_xy(356, 50); step(LAT); check("t2_right_out", int'(in_box), 0);

        // Buffer write then high byte of a 16-wide glyph.
        wr_en = 1'b1; wr_idx = 4'd3; wr_code = 5'd17; wr_blink = 1'b0;
        step(1);
        wr_en = 1'b0;
        at_xy(157, 50);
        step(1);
        check("t3_addr", int'(rom_addr), 545);
        step(LAT - 1);
        check("t3_pixel", int'(pixel), 1);

        // Scale 2x at origin.
        x0 = '0; y0 = '0; scale = 2'd1;
        at_xy(1, 0);   step(1); check("t4_col0", int'(rom_addr), 0);
        at_xy(63, 31); step(LAT); check("t4_far_addr_box", int'(in_box), 1);
        check("t4_far_addr", int'(rom_addr), 63);
        at_xy(63, 32); step(LAT); check("t4_below", int'(in_box), 0);

        // Blink on char 0: 16 ticks visible, 16 blanked, then visible again.
        x0 = 10'd100; y0 = 10'd50; scale = '0;
        wr_en = 1'b1; wr_idx = 4'd0; wr_code = 5'd0; wr_blink = 1'b1;
        step(1);
        wr_en = 1'b0;
        at_xy(100, 50);
        step(LAT);
        check("t5_visible", int'(pixel), 1);
        for (int k = 0; k < 16; k++) begin
            frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(1);
            if (k == 14) begin
                step(LAT);
                check("t5_still_visible", int'(pixel), 1);
            end
        end
        step(LAT);
        check("t5_blanked", int'(pixel), 0);
        for (int k = 0; k < 16; k++) begin
            frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(1);
        end
        step(LAT);
        check("t5_visible_again", int'(pixel), 1);

        // Same-edge write and read of index 2.
        at_xy(132, 50);
        wr_en = 1'b1; wr_idx = 4'd2; wr_code = 5'd9; wr_blink = 1'b0;
        step(1);
        check("t6_old_code", int'(rom_addr), 64);
        wr_en = 1'b0;
        step(1);
        check("t6_new_code", int'(rom_addr), 288);
        step(LAT);
        check("t6_pixel_before_rst", int'(pixel), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_pixel", int'(pixel), 0);
        check("t6_async_addr", int'(rom_addr), 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("t6_identity_code", int'(rom_addr), 64);
        step(LAT - 1);
        check("t6_resume_box", int'(in_box), 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int t, span;
            if (c % 200 == 0) begin
                x0    = 10'($urandom_range(0, 700));
                y0    = 10'($urandom_range(0, 500));
                scale = SCALE_W'($urandom_range(0, 3));
            end
            span = (NCHAR * GW) << scale;
            t = int'(x0) - 8 + int'($urandom_range(0, span + 16));
            if (t < 0) t = 0;
            if (t > 1023) t = 1023;
            x_pos = 10'(t);
            t = int'(y0) - 4 + int'($urandom_range(0, (GH << scale) + 8));
            if (t < 0) t = 0;
            if (t > 1023) t = 1023;
            y_pos = 10'(t);
            wr_en      = ($urandom_range(0, 7) == 0);
            wr_idx     = 4'($urandom_range(0, NCHAR - 1));
            wr_code    = 5'($urandom_range(0, 31));
            wr_blink   = 1'($urandom_range(0, 1));
            frame_tick = ($urandom_range(0, 9) == 0);
            step(1);
        end
        wr_en = 1'b0; frame_tick = 1'b0;
        step(LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
